// File: rtl/not_16_arbiter.sv
// not_16_arbiter: two-requester front end for a single 16-bit inverter.
//
// Two requesters compete for one my_not_16 instance through a combinational
// round-robin grant. The inverted operand lands in a one-entry output register
// with valid/ready handshaking. A full register can retire its result and load
// the next one on the same edge, so throughput is one result per cycle.
//
// Parameters:
//   RESET_PRIO  requester (0 or 1) that wins a tie straight out of reset
// Ports:
//   clk                     rising-edge clock
//   reset                   asynchronous, active-high reset
//   req0_valid/data/ready   requester 0 handshake and 16-bit operand
//   req1_valid/data/ready   requester 1 handshake and 16-bit operand
//   resp_valid/data/id      registered result, its owner, and a valid flag
//   resp_ready              consumer takes the result when high with resp_valid

// Shared inverter. This is the only inversion datapath in the block.
module my_not_16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  assign y = ~a;
endmodule

module not_16_arbiter #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_id,
  input  logic        resp_ready
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t      state_q;
  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic        prio_q;

  logic        grant0;
  logic        grant1;
  logic        grant_any;
  logic        accept_ok;
  logic        accept;
  logic [15:0] operand;
  logic [15:0] inv_result;

  // A lone valid requester always wins; a tie goes to the priority pointer.
  always_comb begin
    grant0    = req0_valid & (~req1_valid | ~prio_q);
    grant1    = req1_valid & (~req0_valid |  prio_q);
    grant_any = grant0 | grant1;
  end

  // Room exists when empty, or when the held result leaves on this edge.
  always_comb begin
    accept_ok = (state_q == IDLE) | ((state_q == FULL) & resp_ready);
  end

  // The reset term keeps both readies low while reset is held, even though the
  // FSM already sits in IDLE.
  always_comb begin
    req0_ready = accept_ok & grant0 & ~reset;
    req1_ready = accept_ok & grant1 & ~reset;
    accept     = req0_ready | req1_ready;
  end

  // Grants are mutually exclusive, so a plain 2:1 mux feeds the inverter.
  always_comb begin
    operand = grant1 ? req1_data : req0_data;
  end

  my_not_16 u_not (
    .a (operand),
    .y (inv_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_id    <= 1'b0;
      prio_q     <= (RESET_PRIO != 0);
    end else begin
      unique case (state_q)
        IDLE: begin
          // resp_ready is irrelevant here; only a grant moves us.
          if (grant_any) begin
            state_q    <= FULL;
            resp_valid <= 1'b1;
            resp_data  <= inv_result;
            resp_id    <= grant1;
            prio_q     <= ~grant1;
          end
        end
        FULL: begin
          if (resp_ready) begin
            if (grant_any) begin
              // Retire and reload on the same edge; stay FULL.
              resp_valid <= 1'b1;
              resp_data  <= inv_result;
              resp_id    <= grant1;
              prio_q     <= ~grant1;
            end else begin
              state_q    <= IDLE;
              resp_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_not_16_arbiter.sv
module tb_not_16_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_id;
  logic        resp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the randomized fairness phase.
  logic        prio_m;
  logic        full_m;
  logic        id_m;
  logic [15:0] data_m;
  logic        ok_m;
  logic [1:0]  rdy_m;
  int          cnt0;
  int          cnt1;
  int          diff;

  not_16_arbiter #(
    .RESET_PRIO (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic v, input logic id, input logic [15:0] d);
    check_eq(tag, 32'({resp_valid, resp_id, resp_data}), 32'({v, id, d}));
  endtask

  task automatic check_rdy(input string tag, input logic [1:0] exp);
    check_eq(tag, 32'({req1_ready, req0_ready}), 32'(exp));
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 16'h1234;
    req1_valid = 1'b0;
    req1_data  = 16'h0000;
    resp_ready = 1'b0;

    // Reset values, readies low even with a valid requester.
    repeat (2) @(negedge clk);
    #1;
    check_resp("reset_resp", 1'b0, 1'b0, 16'h0000);
    check_rdy("reset_rdy", 2'b00);

    // Single requester, first edge after reset release accepts.
    @(negedge clk);
    reset      = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 16'h0000;
    resp_ready = 1'b1;
    #1;
    check_rdy("single_rdy", 2'b01);
    @(negedge clk);
    req0_valid = 1'b0;
    check_resp("single_resp", 1'b1, 1'b0, 16'hFFFF);
    #1;
    check_rdy("single_norq_rdy", 2'b00);

    // Drain: valid for exactly one cycle, then IDLE stays IDLE.
    @(negedge clk);
    check_eq("drain_valid_low", 32'(resp_valid), 32'(0));
    @(negedge clk);
    check_eq("idle_stays", 32'(resp_valid), 32'(0));

    // Reset pulse between edges restores priority to requester 0.
    reset = 1'b1;
    #1;
    reset = 1'b0;

    // Contention: grants alternate 0,1,0,1 with one result per cycle.
    req0_valid = 1'b1;
    req0_data  = 16'hFFFF;
    req1_valid = 1'b1;
    req1_data  = 16'hF8FC;
    resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_rdy("contend_rdy", (i % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      check_resp("contend_resp", 1'b1, 1'((i % 2)), (i % 2 == 1) ? 16'h0703 : 16'h0000);
    end

    // Backpressure while holding id 1 / 16'h0703.
    resp_ready = 1'b0;
    #1;
    check_rdy("bp_rdy_first", 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_rdy("bp_rdy", 2'b00);
      check_resp("bp_hold", 1'b1, 1'b1, 16'h0703);
    end
    resp_ready = 1'b1;
    #1;
    check_rdy("bp_release_rdy", 2'b01);
    @(negedge clk);
    check_resp("bp_new", 1'b1, 1'b0, 16'h0000);

    // Async reset while FULL clears outputs before the next clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_resp("async_clr", 1'b0, 1'b0, 16'h0000);
    check_rdy("async_rdy", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_rdy("post_reset_prio", 2'b01);
    @(negedge clk);
    check_resp("post_reset_accept", 1'b1, 1'b0, 16'h0000);

    // Drain to IDLE; last acceptance was from requester 0.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("drain2_valid_low", 32'(resp_valid), 32'(0));

    // Fairness under random backpressure and random operands.
    prio_m = 1'b1;
    full_m = 1'b0;
    id_m   = 1'b0;
    data_m = 16'h0000;
    cnt0   = 0;
    cnt1   = 0;
    for (int c = 0; c < 100; c++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
      #1;
      ok_m  = ~full_m | resp_ready;
      rdy_m = ok_m ? (prio_m ? 2'b10 : 2'b01) : 2'b00;
      check_rdy("fair_rdy", rdy_m);
      if (req0_ready) cnt0++;
      if (req1_ready) cnt1++;
      if (ok_m) begin
        full_m = 1'b1;
        id_m   = prio_m;
        data_m = prio_m ? ~req1_data : ~req0_data;
        prio_m = ~prio_m;
      end
      @(negedge clk);
      check_resp("fair_resp", full_m, id_m, data_m);
    end
    diff = (cnt0 > cnt1) ? (cnt0 - cnt1) : (cnt1 - cnt0);
    check_eq("fair_balance", 32'(diff <= 1), 32'(1));
    check_eq("fair_some_accepts", 32'((cnt0 + cnt1) > 0), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/not_16_arbiter.md
NOT_16_ARBITER -- requirements
Module: not_16_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 0, index of the requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an operand.
REQ-005 req0_data  input  16  requester 0 operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle when high with req0_valid.
REQ-007 req1_valid  input  1  requester 1 presents an operand.
REQ-008 req1_data  input  16  requester 1 operand.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle when high with req1_valid.
REQ-010 resp_valid  output  1  result held in output register.
REQ-011 resp_data  output  16  bitwise inverse of the accepted operand.
REQ-012 resp_id  output  1  index of the requester that owns resp_data.
REQ-013 resp_ready  input  1  consumer takes the result this cycle when high with resp_valid.

Function
REQ-014 The block SHALL share one my_not_16 instance between both requesters; no other inversion logic SHALL exist.
REQ-015 FSM states SHALL be IDLE (output register empty) and FULL (result held).
REQ-016 accept_ok SHALL equal (state==IDLE) or (state==FULL and resp_ready).
REQ-017 Grant SHALL be combinational: only requester valid -> that one; both valid -> requester at prio pointer; neither -> no grant.
REQ-018 reqN_ready SHALL be high only when accept_ok and requester N is granted; never both readies high in one cycle.
REQ-019 reqN_ready SHALL NOT depend on reqN_valid of the other requester except through REQ-017 grant selection.
REQ-020 On acceptance at edge N, resp_data SHALL load ~reqN_data, resp_id SHALL load N, and resp_valid SHALL be high from the cycle after edge N (latency 1).
REQ-021 After any acceptance from requester N, the prio pointer SHALL point to the other requester; without acceptance it SHALL hold.
REQ-022 FULL with resp_ready low SHALL hold resp_data, resp_id and resp_valid stable; both readies SHALL be low.
REQ-023 FULL with resp_ready high and a grant SHALL retire the held result and load the new one at the same edge (one result per cycle throughput); state stays FULL.
REQ-024 FULL with resp_ready high and no grant SHALL return to IDLE and drop resp_valid next cycle.
REQ-025 IDLE with a grant SHALL go to FULL; IDLE with no grant SHALL stay IDLE.
REQ-026 resp_ready while IDLE SHALL be ignored.
REQ-027 Operand value SHALL not affect control; 16'h0000 and 16'hFFFF are ordinary data.

Reset
REQ-028 While reset high: state IDLE, resp_valid 0, resp_data 16'h0000, resp_id 0, prio pointer RESET_PRIO, both readies 0.
REQ-029 Reset assertion mid-transaction SHALL discard the held result immediately without waiting for clk.
REQ-030 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-031 Single requester: req0 valid data 16'h0000, resp_ready 1 -> req0_ready 1, next cycle resp_valid 1, resp_data 16'hFFFF, resp_id 0.
REQ-032 Contention, RESET_PRIO 0: both valid (req0 16'hFFFF, req1 16'hF8FC) held, resp_ready 1 -> results alternate id 0 (16'h0000), id 1 (16'h0703), id 0, ... one per cycle.
REQ-033 Backpressure: result 16'h0703 held, resp_ready 0 for 3 cycles, both requesters valid -> both readies 0, resp_data/resp_id stable; resp_ready 1 -> new operand accepted same edge.
REQ-034 Drain: one accepted operand, then no valid, resp_ready 1 -> resp_valid high exactly one cycle, then IDLE.
REQ-035 Async reset: assert reset between clock edges while FULL -> resp_valid 0 and resp_data 16'h0000 before next edge; after release, priority RESET_PRIO.
REQ-036 Fairness: both valid for 100 cycles, resp_ready random -> accepted counts differ by at most 1.
